// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral init sequencer.
// Holds the opcode constants, the ROM entry layout, the FSM state type and the
// default power-up script. A second script (index 1) is used for bring-up of the
// sequencer itself. It has zero-length delays and no END, so it exercises pc overflow.
package spi_pkg;

    localparam logic [1:0] OP_PIN = 2'd0;
    localparam logic [1:0] OP_CMD = 2'd1;
    localparam logic [1:0] OP_DLY = 2'd2;
    localparam logic [1:0] OP_END = 2'd3;

    // Pin vector layout is {vbat_n, vdd_n, res_n, dc}; supplies off, reset released.
    localparam logic [3:0] PINS_RESET = 4'b1110;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] arg;
    } entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StWaitSpi,
        StWaitDly,
        StGap,
        StFin
    } state_e;

    function automatic entry_t mk_entry(input logic [1:0] op, input logic [15:0] arg);
        entry_t e;
        e.op  = op;
        e.arg = arg;
        return e;
    endfunction

    // Default OLED power-up script.
    function automatic entry_t init_rom(input int unsigned idx);
        entry_t e;
        case (idx)
            0:       e = mk_entry(OP_PIN, 16'h000A); // vdd_n=0
            1:       e = mk_entry(OP_DLY, 16'd1);
            2:       e = mk_entry(OP_PIN, 16'h0008); // res_n=0
            3:       e = mk_entry(OP_DLY, 16'd1);
            4:       e = mk_entry(OP_PIN, 16'h000A); // res_n=1
            5:       e = mk_entry(OP_CMD, 16'h00AE);
            6:       e = mk_entry(OP_CMD, 16'h008D);
            7:       e = mk_entry(OP_CMD, 16'h0014);
            8:       e = mk_entry(OP_PIN, 16'h0002); // vbat_n=0
            9:       e = mk_entry(OP_DLY, 16'd100);
            10:      e = mk_entry(OP_CMD, 16'h00AF);
            default: e = mk_entry(OP_END, 16'h0000);
        endcase
        return e;
    endfunction

    // Alternate script: even entries DLY 0, odd entries PIN ~idx, never END.
    function automatic entry_t alt_rom(input int unsigned idx);
        entry_t     e;
        logic [3:0] nib;
        nib = ~idx[3:0];
        if (idx[0] == 1'b0) begin
            e = mk_entry(OP_DLY, 16'h0000);
        end else begin
            e = mk_entry(OP_PIN, {12'h000, nib});
        end
        return e;
    endfunction

endpackage

// File: rtl/spi_init_rom.sv
// Script ROM for spi_init_seq: combinational lookup of the packaged script.
// Ports:
//   addr_i  - step index (pc)
//   entry_o - {op, arg} entry at addr_i
module spi_init_rom
    import spi_pkg::*;
#(
    parameter int unsigned MaxSteps = 32,
    parameter int unsigned Script   = 0,
    parameter int unsigned PcW      = $clog2(MaxSteps)
) (
    input  logic [PcW-1:0] addr_i,
    output entry_t         entry_o
);

    always_comb begin
        if (Script == 1) begin
            entry_o = alt_rom(32'(addr_i));
        end else begin
            entry_o = init_rom(32'(addr_i));
        end
    end

endmodule

// File: rtl/spi_init_seq.sv
// Scripted power-up sequencer for an SPI peripheral (e.g. an OLED panel).
// Walks the script ROM after a start pulse. It drives the ms delay timer and the SPI
// byte transmitter, and it drives the panel control pins. All outputs are registered.
// Ports:
//   clk_i, rst_ni            - clock, synchronous active-low reset
//   start_i                  - one-cycle run request (ignored while busy)
//   busy_o, done_o           - script running / script finished
//   dly_en_o, dly_ms_o       - delay timer enable and length
//   dly_done_i               - delay timer done level
//   spi_send_o, spi_data_o   - byte transmit request and byte
//   spi_done_i               - transmitter completion pulse
//   dc_o, res_n_o            - data/command select, peripheral reset (active low)
//   vdd_n_o, vbat_n_o        - logic / panel supply enables (active low)
module spi_init_seq
    import spi_pkg::*;
#(
    parameter int unsigned MaxSteps = 32,
    parameter int unsigned MsW      = 32,
    parameter int unsigned Script   = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           dly_en_o,
    output logic [MsW-1:0] dly_ms_o,
    input  logic           dly_done_i,
    output logic           spi_send_o,
    output logic [7:0]     spi_data_o,
    input  logic           spi_done_i,
    output logic           dc_o,
    output logic           res_n_o,
    output logic           vdd_n_o,
    output logic           vbat_n_o
);

    localparam int unsigned    PcW    = $clog2(MaxSteps);
    localparam logic [PcW-1:0] PcLast = PcW'(MaxSteps - 1);

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic           ovf_q, ovf_d;
    entry_t         entry_q, entry_d;
    entry_t         rom_entry;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dly_en_q, dly_en_d;
    logic [MsW-1:0] dly_ms_q, dly_ms_d;
    logic           spi_send_q, spi_send_d;
    logic [7:0]     spi_data_q, spi_data_d;
    logic [3:0]     pins_q, pins_d;
    logic           advance;

    spi_init_rom #(
        .MaxSteps(MaxSteps),
        .Script  (Script),
        .PcW     (PcW)
    ) u_rom (
        .addr_i (pc_q),
        .entry_o(rom_entry)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ovf_d      = ovf_q;
        entry_d    = entry_q;
        busy_d     = busy_q;
        done_d     = done_q;
        dly_en_d   = dly_en_q;
        dly_ms_d   = dly_ms_q;
        spi_send_d = spi_send_q;
        spi_data_d = spi_data_q;
        pins_d     = pins_q;
        advance    = 1'b0;

        unique case (state_q)
            StIdle, StFin: begin
                if (start_i) begin
                    pc_d    = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Once the last entry has run, the script ends even without an END.
                entry_d = ovf_q ? mk_entry(OP_END, 16'h0000) : rom_entry;
                state_d = StExec;
            end
            StExec: begin
                case (entry_q.op)
                    OP_PIN: begin
                        pins_d  = entry_q.arg[3:0];
                        advance = 1'b1;
                    end
                    OP_CMD: begin
                        spi_send_d = 1'b1;
                        spi_data_d = entry_q.arg[7:0];
                        pins_d[0]  = entry_q.arg[8];
                        state_d    = StWaitSpi;
                    end
                    OP_DLY: begin
                        if (entry_q.arg != 16'h0000) begin
                            dly_en_d = 1'b1;
                            dly_ms_d = MsW'(entry_q.arg);
                            state_d  = StWaitDly;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                    default: begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFin;
                    end
                endcase
            end
            StWaitSpi: begin
                if (spi_done_i) begin
                    spi_send_d = 1'b0;
                    advance    = 1'b1;
                end
            end
            StWaitDly: begin
                if (dly_done_i) begin
                    dly_en_d = 1'b0;
                    state_d  = StGap;
                end
            end
            // One cycle with dly_en low lets the timer clear its done level.
            StGap: advance = 1'b1;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            state_d = StFetch;
            if (pc_q == PcLast) begin
                ovf_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ovf_q      <= 1'b0;
            entry_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dly_en_q   <= 1'b0;
            dly_ms_q   <= '0;
            spi_send_q <= 1'b0;
            spi_data_q <= '0;
            pins_q     <= PINS_RESET;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ovf_q      <= ovf_d;
            entry_q    <= entry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dly_en_q   <= dly_en_d;
            dly_ms_q   <= dly_ms_d;
            spi_send_q <= spi_send_d;
            spi_data_q <= spi_data_d;
            pins_q     <= pins_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign dly_en_o   = dly_en_q;
    assign dly_ms_o   = dly_ms_q;
    assign spi_send_o = spi_send_q;
    assign spi_data_o = spi_data_q;
    assign vbat_n_o   = pins_q[3];
    assign vdd_n_o    = pins_q[2];
    assign res_n_o    = pins_q[1];
    assign dc_o       = pins_q[0];

endmodule

// File: tb/tb_spi_init_seq.sv
// Self-checking bench for spi_init_seq.
// A script-level model lists the SPI bytes, the delays and the final pins expected from
// a script. A monitor records what the DUT actually did. The timer and SPI responders
// use randomised latencies, an optional stale done level and spurious done pulses.
module tb_spi_init_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done, dly_en, spi_send, dc, res_n, vdd_n, vbat_n;
    logic [31:0] dly_ms;
    logic [7:0]  spi_data;
    logic        dly_done, spi_done;

    logic        start_a;
    logic        busy_a, done_a, dly_en_a, spi_send_a, dc_a, res_n_a, vdd_n_a, vbat_n_a;
    logic [31:0] dly_ms_a;
    logic [7:0]  spi_data_a;
    logic        dly_done_a, spi_done_a;

    spi_init_seq #(.MaxSteps(32), .MsW(32), .Script(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .dly_en_o(dly_en), .dly_ms_o(dly_ms), .dly_done_i(dly_done),
        .spi_send_o(spi_send), .spi_data_o(spi_data), .spi_done_i(spi_done),
        .dc_o(dc), .res_n_o(res_n), .vdd_n_o(vdd_n), .vbat_n_o(vbat_n)
    );

    spi_init_seq #(.MaxSteps(32), .MsW(32), .Script(1)) dut_alt (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .dly_en_o(dly_en_a), .dly_ms_o(dly_ms_a), .dly_done_i(dly_done_a),
        .spi_send_o(spi_send_a), .spi_data_o(spi_data_a), .spi_done_i(spi_done_a),
        .dc_o(dc_a), .res_n_o(res_n_a), .vdd_n_o(vdd_n_a), .vbat_n_o(vbat_n_a)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Responder knobs (written by the main sequence only).
    int lat_dly = 5;
    int lat_spi = 4;
    bit stale = 1'b0;
    bit noise = 1'b0;
    bit hold_long = 1'b0;

    // Monitor records (written by the monitor only).
    logic [8:0]  obs_spi[$];
    logic [31:0] obs_ms[$];
    int          en_len[$];
    int          gaps[$];
    int          busy_rises = 0;
    int          stab_err = 0;

    // Model outputs.
    logic [8:0]  exp_spi[$];
    logic [31:0] exp_ms[$];
    logic [3:0]  exp_pins;
    int          exp_steps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Script table: {op, arg}; op 0=PIN {vbat_n,vdd_n,res_n,dc}, 1=CMD, 2=DLY, 3=END.
    function automatic logic [17:0] tb_entry(input int sel, input int i);
        logic [17:0] e;
        logic [3:0]  nib;
        nib = ~i[3:0];
        if (sel == 1) begin
            if (i % 2 == 0) e = {2'd2, 16'd0};
            else            e = {2'd0, 12'd0, nib};
        end else begin
            case (i)
                0:       e = {2'd0, 16'b1010};
                1:       e = {2'd2, 16'd1};
                2:       e = {2'd0, 16'b1000};
                3:       e = {2'd2, 16'd1};
                4:       e = {2'd0, 16'b1010};
                5:       e = {2'd1, 16'h00AE};
                6:       e = {2'd1, 16'h008D};
                7:       e = {2'd1, 16'h0014};
                8:       e = {2'd0, 16'b0010};
                9:       e = {2'd2, 16'd100};
                10:      e = {2'd1, 16'h00AF};
                default: e = {2'd3, 16'd0};
            endcase
        end
        return e;
    endfunction

    task automatic build_model(input int sel);
        logic [17:0] e;
        exp_spi.delete();
        exp_ms.delete();
        exp_pins  = 4'b1110;
        exp_steps = 0;
        for (int i = 0; i < 32; i++) begin
            e = tb_entry(sel, i);
            if (e[17:16] == 2'd3) break;
            exp_steps++;
            case (e[17:16])
                2'd0: exp_pins = e[3:0];
                2'd1: begin
                    exp_spi.push_back(e[8:0]);
                    exp_pins[0] = e[8];
                end
                default: if (e[15:0] != 16'd0) exp_ms.push_back(32'(e[15:0]));
            endcase
        end
    endtask

    // Delay timer model: done after lat_dly cycles of enable; clears when enable drops
    // (one cycle late in stale mode).
    initial begin
        int cnt;
        int low;
        cnt = 0;
        low = 0;
        dly_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dly_en) begin
                low = 0;
                cnt++;
                dly_done = (cnt >= lat_dly) && !(hold_long && dly_ms == 32'd100);
            end else begin
                cnt = 0;
                low++;
                if (!stale || low >= 2) dly_done = noise && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // SPI transmitter model: one-cycle done pulse lat_spi cycles after the request.
    initial begin
        int scnt;
        scnt = 0;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_send) begin
                scnt++;
                spi_done = (scnt == lat_spi);
            end else begin
                scnt = 0;
                spi_done = noise && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor.
    initial begin
        bit          p_send, p_en, p_busy, seen_dly;
        logic [8:0]  cur_spi;
        logic [31:0] cur_ms;
        int          hi_run, low_run;
        p_send = 0; p_en = 0; p_busy = 0; seen_dly = 0;
        cur_spi = '0; cur_ms = '0; hi_run = 0; low_run = 0;
        forever begin
            @(negedge clk);
            if (spi_send && !p_send) begin
                cur_spi = {dc, spi_data};
                obs_spi.push_back(cur_spi);
            end else if (spi_send && ({dc, spi_data} != cur_spi)) begin
                stab_err++;
            end
            if (dly_en) begin
                if (!p_en) begin
                    cur_ms = dly_ms;
                    obs_ms.push_back(cur_ms);
                    if (seen_dly) gaps.push_back(low_run);
                    seen_dly = 1;
                    hi_run = 0;
                end else if (dly_ms != cur_ms) begin
                    stab_err++;
                end
                hi_run++;
            end else begin
                if (p_en) begin
                    en_len.push_back(hi_run);
                    low_run = 1;
                end else begin
                    low_run++;
                end
            end
            if (busy && !p_busy) busy_rises++;
            p_send = spi_send;
            p_en = dly_en;
            p_busy = busy;
        end
    end

    task automatic run_main(input bit poke);
        int b_spi, b_ms, b_len, b_gap, b_rise, se0, n;
        build_model(0);
        b_spi = obs_spi.size();
        b_ms = obs_ms.size();
        b_len = en_len.size();
        b_gap = gaps.size();
        b_rise = busy_rises;
        se0 = stab_err;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        if (poke) begin
            n = 0;
            while (!spi_send && n < 2000) begin
                @(negedge clk);
                n++;
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_final", 32'(busy), 32'd0);
        chk("n_spi", 32'(obs_spi.size() - b_spi), 32'(exp_spi.size()));
        for (int i = 0; i < exp_spi.size() && b_spi + i < obs_spi.size(); i++)
            chk("spi_dc_byte", 32'(obs_spi[b_spi + i]), 32'(exp_spi[i]));
        chk("n_dly", 32'(obs_ms.size() - b_ms), 32'(exp_ms.size()));
        for (int i = 0; i < exp_ms.size() && b_ms + i < obs_ms.size(); i++)
            chk("dly_ms", obs_ms[b_ms + i], exp_ms[i]);
        for (int i = b_len; i < en_len.size(); i++)
            chk("dly_en_len", 32'(en_len[i]), 32'(lat_dly));
        for (int i = b_gap; i < gaps.size(); i++)
            chk("dly_gap_ge3", 32'(gaps[i] >= 3), 32'd1);
        chk("final_pins", 32'({vbat_n, vdd_n, res_n, dc}), 32'(exp_pins));
        chk("single_run", 32'(busy_rises - b_rise), 32'd1);
        chk("stable_outputs", 32'(stab_err - se0), 32'd0);
    endtask

    initial begin
        int n, hi, en_seen, send_seen;
        rst_n = 1'b0;
        start = 1'b0;
        start_a = 1'b0;
        // Alternate DUT sees permanently asserted done inputs; neither may be consumed.
        dly_done_a = 1'b1;
        spi_done_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pins", 32'({vbat_n, vdd_n, res_n, dc}), 32'b1110);
        chk("rst_dly_en", 32'(dly_en), 32'd0);
        chk("rst_dly_ms", dly_ms, 32'd0);
        chk("rst_spi_send", 32'(spi_send), 32'd0);
        chk("rst_spi_data", 32'(spi_data), 32'd0);

        // Fixed latencies, restart attempt while the first byte is in flight.
        run_main(1'b1);
        // Timer done held one cycle past the enable.
        stale = 1'b1;
        run_main(1'b0);
        // Randomised responder latencies and spurious done pulses.
        for (int r = 0; r < 5; r++) begin
            lat_dly = int'($urandom_range(1, 8));
            lat_spi = int'($urandom_range(1, 6));
            stale = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            run_main(1'b0);
        end
        lat_dly = 5;
        lat_spi = 4;
        stale = 1'b0;
        noise = 1'b0;

        // Reset during the 100 ms delay.
        hold_long = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(dly_en && dly_ms == 32'd100) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_long_dly", 32'(dly_en && dly_ms == 32'd100), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_dly_en", 32'(dly_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vdd_n", 32'(vdd_n), 32'd1);
        chk("abort_vbat_n", 32'(vbat_n), 32'd1);
        chk("abort_res_n", 32'(res_n), 32'd1);
        rst_n = 1'b1;
        hold_long = 1'b0;
        @(negedge clk);
        run_main(1'b0);

        // Alternate script: DLY 0 steps and pc overflow.
        build_model(1);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        hi = 0;
        en_seen = 0;
        send_seen = 0;
        while (busy_a && hi < 300) begin
            hi++;
            if (dly_en_a) en_seen++;
            if (spi_send_a) send_seen++;
            @(negedge clk);
        end
        chk("alt_busy_cycles", 32'(hi), 32'(2 * (exp_steps + 1)));
        chk("alt_no_dly_en", 32'(en_seen), 32'd0);
        chk("alt_no_spi", 32'(send_seen), 32'd0);
        chk("alt_done", 32'(done_a), 32'd1);
        chk("alt_pins", 32'({vbat_n_a, vdd_n_a, res_n_a, dc_a}), 32'(exp_pins));
        chk("alt_dly_ms", dly_ms_a, 32'd0);
        chk("alt_spi_data", 32'(spi_data_a), 32'd0);
        repeat (5) @(negedge clk);
        chk("alt_done_held", 32'(done_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
